ofs_plat_avalon_mem_rdwr_responder: RTL and testbench

- Responder (slave) end of the split read/write Avalon host-memory bus that the host-channel shims present to AFU masters.
- Backs the bus with an on-chip word array, so plat_if_tests can exercise AFU masters without a host.
- Accepts read and write bursts independently. Streams read data one beat per cycle and returns one write response per write burst.
- Instantiated in test harnesses in place of the platform host channel.

---
 rtl/ofs_plat_avalon_responder_pkg.sv | 22 ++
 rtl/ofs_plat_avalon_responder_ram.sv | 51 +++++
 rtl/ofs_plat_avalon_mem_rdwr_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_ofs_plat_avalon_mem_rdwr_responder.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_plat_avalon_responder_pkg.sv
// Shared types for the Avalon split read/write memory responder.
//   t_resp     : Avalon response codes carried on rd_response / wr_response.
//   t_rd_state : read-side FSM states.
//   t_wr_state : write-side FSM states.
package ofs_plat_avalon_responder_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } t_resp;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } t_rd_state;

    typedef enum logic {
        WR_FIRST = 1'b0,
        WR_BURST = 1'b1
    } t_wr_state;

endpackage

// File: rtl/ofs_plat_avalon_responder_ram.sv
// Simple dual-port word array backing the responder.
//   clk, rst_n        : clock; async active-low reset (read register only,
//                       array contents are never reset).
//   wr_en_i/wr_idx_i  : write port, one word per cycle.
//   wr_data_i/wr_be_i : write data and per-byte enables.
//   rd_idx_i          : read index, sampled every cycle.
//   rd_data_o         : registered read data, one cycle after rd_idx_i.
// A read and a write to the same index in one cycle return the old word.
module ofs_plat_avalon_responder_ram #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en_i,
    input  logic [ADDR_WIDTH-1:0]   wr_idx_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic [ADDR_WIDTH-1:0]   rd_idx_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o
);

    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    // Non-blocking update of mem_q in the block above means this read
    // always sees the pre-write word on a same-index collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ofs_plat_avalon_mem_rdwr_responder.sv
// Responder end of the split read/write Avalon host-memory bus, backed by
// an on-chip word array so AFU masters can be exercised without a host.
//   clk, reset_n              : clock; async assert / sync release, active-low.
//   rd_*                      : read command in, read beats out (one per cycle).
//   wr_*                      : write beats in, one response pulse per burst.
//   err                       : sticky protocol error flag.
//   rd_state_dbg/wr_state_dbg : current read / write FSM state.
// Optional checking: define OFS_PLAT_AVALON_RESPONDER_CHECK_EN to drive err
// from protocol checks; otherwise err is tied low.
//
// Handshake: a read command is taken on a cycle with rd_read=1 and
// rd_waitrequest=0; a write beat is taken on a cycle with wr_write=1 and
// wr_waitrequest=0. Read beats and write responses have no backpressure.
// Burstcount 0 or above 2^(BURST_CNT_WIDTH-1) is run as one beat with SLVERR.
module ofs_plat_avalon_mem_rdwr_responder
    import ofs_plat_avalon_responder_pkg::*;
#(
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int MEM_ADDR_WIDTH  = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_WIDTH-1:0]      rd_address,
    input  logic                       rd_read,
    input  logic [BURST_CNT_WIDTH-1:0] rd_burstcount,
    input  logic [DATA_WIDTH/8-1:0]    rd_byteenable,
    output logic                       rd_waitrequest,
    output logic [DATA_WIDTH-1:0]      rd_readdata,
    output logic                       rd_readdatavalid,
    output logic [1:0]                 rd_response,
    input  logic [ADDR_WIDTH-1:0]      wr_address,
    input  logic                       wr_write,
    input  logic [BURST_CNT_WIDTH-1:0] wr_burstcount,
    input  logic [DATA_WIDTH-1:0]      wr_writedata,
    input  logic [DATA_WIDTH/8-1:0]    wr_byteenable,
    output logic                       wr_waitrequest,
    output logic                       wr_writeresponsevalid,
    output logic [1:0]                 wr_response,
    output logic                       err,
    output logic                       rd_state_dbg,
    output logic                       wr_state_dbg
);

    localparam logic [BURST_CNT_WIDTH-1:0] ONE_BEAT  = BURST_CNT_WIDTH'(1);
    localparam logic [BURST_CNT_WIDTH-1:0] MAX_BURST = ONE_BEAT << (BURST_CNT_WIDTH - 1);

    function automatic logic burst_legal(input logic [BURST_CNT_WIDTH-1:0] bc);
        return (bc != '0) && (bc <= MAX_BURST);
    endfunction

    // Held low until the first edge after reset release so both
    // waitrequests read 1 during reset and for that first cycle.
    logic live_q;

    t_rd_state                  rd_state_q, rd_state_d;
    logic [MEM_ADDR_WIDTH-1:0]  rd_addr_q,  rd_addr_d;
    logic [BURST_CNT_WIDTH-1:0] rd_rem_q,   rd_rem_d;
    t_resp                      rd_resp_q,  rd_resp_d;

    t_wr_state                  wr_state_q, wr_state_d;
    logic [MEM_ADDR_WIDTH-1:0]  wr_addr_q,  wr_addr_d;
    logic [BURST_CNT_WIDTH-1:0] wr_rem_q,   wr_rem_d;
    t_resp                      wr_code_q,  wr_code_d;
    logic                       wr_rsp_q,   wr_rsp_d;

    logic                       rd_accept, rd_legal, wr_beat, wr_legal;
    logic [MEM_ADDR_WIDTH-1:0]  ram_rd_idx, ram_wr_idx;
    logic [DATA_WIDTH-1:0]      ram_rd_data;

    assign rd_legal  = burst_legal(rd_burstcount);
    assign wr_legal  = burst_legal(wr_burstcount);
    assign rd_accept = rd_read && !rd_waitrequest;
    assign wr_beat   = wr_write && !wr_waitrequest;

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_q     <= 1'b0;
            rd_state_q <= RD_IDLE;
            rd_addr_q  <= '0;
            rd_rem_q   <= '0;
            rd_resp_q  <= RESP_OKAY;
            wr_state_q <= WR_FIRST;
            wr_addr_q  <= '0;
            wr_rem_q   <= '0;
            wr_code_q  <= RESP_OKAY;
            wr_rsp_q   <= 1'b0;
        end else begin
            live_q     <= 1'b1;
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_rem_q   <= rd_rem_d;
            rd_resp_q  <= rd_resp_d;
            wr_state_q <= wr_state_d;
            wr_addr_q  <= wr_addr_d;
            wr_rem_q   <= wr_rem_d;
            wr_code_q  <= wr_code_d;
            wr_rsp_q   <= wr_rsp_d;
        end
    end

    // ---------------- read next state ----------------
    // rd_rem_q counts beats still to present, including the one on the bus
    // this cycle. The array read for the next beat is issued one cycle ahead
    // so data lands with no bubble; an accepted command reads rd_address
    // directly so its first beat appears on the very next cycle.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_rem_d   = rd_rem_q;
        rd_resp_d  = rd_resp_q;
        ram_rd_idx = rd_addr_q;
        if (rd_state_q == RD_BURST && rd_rem_q != ONE_BEAT) begin
            rd_addr_d = rd_addr_q + 1'b1;
            rd_rem_d  = rd_rem_q - 1'b1;
        end else if (rd_accept) begin
            // Reached only from RD_IDLE or on the last beat of a burst.
            ram_rd_idx = rd_address[MEM_ADDR_WIDTH-1:0];
            rd_addr_d  = rd_address[MEM_ADDR_WIDTH-1:0] + 1'b1;
            rd_rem_d   = rd_legal ? rd_burstcount : ONE_BEAT;
            rd_resp_d  = rd_legal ? RESP_OKAY : RESP_SLVERR;
            rd_state_d = RD_BURST;
        end else begin
            rd_state_d = RD_IDLE;
        end
    end

    // ---------------- read outputs ----------------
    always_comb begin
        rd_waitrequest   = !live_q || (rd_state_q == RD_BURST && rd_rem_q != ONE_BEAT);
        rd_readdatavalid = (rd_state_q == RD_BURST);
        rd_readdata      = ram_rd_data;
        rd_response      = (rd_state_q == RD_BURST) ? rd_resp_q : RESP_OKAY;
        rd_state_dbg     = rd_state_q;
    end

    // ---------------- write next state ----------------
    always_comb begin
        wr_state_d = wr_state_q;
        wr_addr_d  = wr_addr_q;
        wr_rem_d   = wr_rem_q;
        wr_code_d  = wr_code_q;
        wr_rsp_d   = 1'b0;
        ram_wr_idx = (wr_state_q == WR_FIRST) ? wr_address[MEM_ADDR_WIDTH-1:0] : wr_addr_q;
        if (wr_beat) begin
            wr_addr_d = ram_wr_idx + 1'b1;
            if (wr_state_q == WR_FIRST) begin
                wr_code_d = wr_legal ? RESP_OKAY : RESP_SLVERR;
                if (!wr_legal || wr_burstcount == ONE_BEAT) begin
                    wr_rsp_d = 1'b1;
                end else begin
                    wr_rem_d   = wr_burstcount - 1'b1;
                    wr_state_d = WR_BURST;
                end
            end else if (wr_rem_q == ONE_BEAT) begin
                wr_rsp_d   = 1'b1;
                wr_state_d = WR_FIRST;
            end else begin
                wr_rem_d = wr_rem_q - 1'b1;
            end
        end
    end

    // ---------------- write outputs ----------------
    always_comb begin
        wr_waitrequest        = !live_q;
        wr_writeresponsevalid = wr_rsp_q;
        wr_response           = wr_rsp_q ? wr_code_q : RESP_OKAY;
        wr_state_dbg          = wr_state_q;
    end

    ofs_plat_avalon_responder_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) u_ram (
        .clk      (clk),
        .rst_n    (reset_n),
        .wr_en_i  (wr_beat),
        .wr_idx_i (ram_wr_idx),
        .wr_data_i(wr_writedata),
        .wr_be_i  (wr_byteenable),
        .rd_idx_i (ram_rd_idx),
        .rd_data_o(ram_rd_data)
    );

    // Only the low address bits index the array; byteenable on the read
    // side matters only to the optional checks.
    logic unused_ok;
    assign unused_ok = ^{rd_address, wr_address, rd_byteenable};

`ifdef OFS_PLAT_AVALON_RESPONDER_CHECK_EN
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] wr_first_addr_q;
    logic                  chk_x, chk_bc, chk_be, chk_addr;

    always_comb begin
        chk_x    = $isunknown(rd_read) || $isunknown(wr_write);
        chk_bc   = (rd_accept && !rd_legal) || (wr_beat && wr_state_q == WR_FIRST && !wr_legal);
        chk_be   = rd_read && (rd_byteenable != '1);
        chk_addr = wr_beat && wr_state_q == WR_BURST && (wr_address != wr_first_addr_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q           <= 1'b0;
            wr_first_addr_q <= '0;
        end else begin
            if (chk_x || chk_bc || chk_be || chk_addr) begin
                err_q <= 1'b1;
            end
            if (wr_beat && wr_state_q == WR_FIRST) begin
                wr_first_addr_q <= wr_address;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (chk_x)    $error("avalon responder: rd_read or wr_write is X");
            if (chk_bc)   $error("avalon responder: illegal burstcount");
            if (chk_be)   $error("avalon responder: rd_read with partial rd_byteenable");
            if (chk_addr) $error("avalon responder: wr_address changed mid-burst");
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_responder.sv
// Directed bench for ofs_plat_avalon_mem_rdwr_responder (64-bit data,
// 1024-word array). Inputs are driven 1ns after the rising edge; outputs
// are captured by a monitor on the falling edge.
module tb_ofs_plat_avalon_mem_rdwr_responder;

    localparam int AW  = 48;
    localparam int DW  = 64;
    localparam int BCW = 7;
    localparam int MAW = 10;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [AW-1:0]  rd_address;
    logic           rd_read;
    logic [BCW-1:0] rd_burstcount;
    logic [DW/8-1:0] rd_byteenable;
    logic           rd_waitrequest;
    logic [DW-1:0]  rd_readdata;
    logic           rd_readdatavalid;
    logic [1:0]     rd_response;
    logic [AW-1:0]  wr_address;
    logic           wr_write;
    logic [BCW-1:0] wr_burstcount;
    logic [DW-1:0]  wr_writedata;
    logic [DW/8-1:0] wr_byteenable;
    logic           wr_waitrequest;
    logic           wr_writeresponsevalid;
    logic [1:0]     wr_response;
    logic           err;
    logic           rd_state_dbg;
    logic           wr_state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic exp_err;

    // Scoreboard and monitor capture
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_data[$];
    logic [1:0]    got_resp[$];
    int            got_cyc[$];
    int            rsp_cyc[$];
    logic [1:0]    rsp_code[$];

    ofs_plat_avalon_mem_rdwr_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW), .MEM_ADDR_WIDTH(MAW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_address(rd_address), .rd_read(rd_read), .rd_burstcount(rd_burstcount),
        .rd_byteenable(rd_byteenable), .rd_waitrequest(rd_waitrequest),
        .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid),
        .rd_response(rd_response),
        .wr_address(wr_address), .wr_write(wr_write), .wr_burstcount(wr_burstcount),
        .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable),
        .wr_waitrequest(wr_waitrequest), .wr_writeresponsevalid(wr_writeresponsevalid),
        .wr_response(wr_response), .err(err),
        .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
    );

    // ---------------- clock / cycle counter / monitor ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_readdatavalid === 1'b1) begin
            got_data.push_back(rd_readdata);
            got_resp.push_back(rd_response);
            got_cyc.push_back(cyc);
        end
        if (wr_writeresponsevalid === 1'b1) begin
            rsp_cyc.push_back(cyc);
            rsp_code.push_back(wr_response);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        exp_q.delete();
        got_data.delete();
        got_resp.delete();
        got_cyc.delete();
        rsp_cyc.delete();
        rsp_code.delete();
    endtask

    // Issues one read command; acc is the cycle in which it was accepted.
    task automatic rd_cmd(input logic [AW-1:0] addr, input logic [BCW-1:0] bc, output int acc);
        int guard;
        guard         = 0;
        rd_address    = addr;
        rd_burstcount = bc;
        rd_read       = 1'b1;
        while (rd_waitrequest !== 1'b0 && guard < 50) begin
            tick(1);
            guard++;
        end
        checks++;
        if (guard >= 50) begin
            failures++;
            $display("FAIL rd_accept_timeout waitrequest=%b required=0", rd_waitrequest);
        end
        acc = cyc;
        tick(1);
        rd_read = 1'b0;
    endtask

    // Drives n write beats with data d0, d0+1, ...; last is the cycle of the final beat.
    task automatic wr_beats(input logic [AW-1:0] addr, input logic [BCW-1:0] bc,
                            input logic [DW-1:0] d0, input int n,
                            input logic [DW/8-1:0] be, output int last);
        for (int k = 0; k < n; k++) begin
            wr_address    = addr;
            wr_burstcount = bc;
            wr_writedata  = d0 + DW'(k);
            wr_byteenable = be;
            wr_write      = 1'b1;
            checks++;
            if (wr_waitrequest !== 1'b0) begin
                failures++;
                $display("FAIL wr_waitrequest_beat got=%b required=0", wr_waitrequest);
            end
            last = cyc;
            tick(1);
        end
        wr_write = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        tick(2);
        checks += 8;
        if (rd_waitrequest !== 1'b1)        begin failures++; $display("FAIL rst_rd_waitrequest got=%b required=1", rd_waitrequest); end
        if (wr_waitrequest !== 1'b1)        begin failures++; $display("FAIL rst_wr_waitrequest got=%b required=1", wr_waitrequest); end
        if (rd_readdatavalid !== 1'b0)      begin failures++; $display("FAIL rst_rd_valid got=%b required=0", rd_readdatavalid); end
        if (wr_writeresponsevalid !== 1'b0) begin failures++; $display("FAIL rst_wr_rspvalid got=%b required=0", wr_writeresponsevalid); end
        if (rd_response !== 2'b00)          begin failures++; $display("FAIL rst_rd_response got=%b required=00", rd_response); end
        if (wr_response !== 2'b00)          begin failures++; $display("FAIL rst_wr_response got=%b required=00", wr_response); end
        if (err !== 1'b0)                   begin failures++; $display("FAIL rst_err got=%b required=0", err); end
        if (rd_readdata !== '0)             begin failures++; $display("FAIL rst_rd_readdata got=%h required=0", rd_readdata); end
        reset_n = 1'b1;
        checks++;
        if (rd_waitrequest !== 1'b1) begin failures++; $display("FAIL rel_waitrequest_hold got=%b required=1", rd_waitrequest); end
        tick(1);
        checks += 2;
        if (rd_waitrequest !== 1'b0) begin failures++; $display("FAIL rel_rd_waitrequest got=%b required=0", rd_waitrequest); end
        if (wr_waitrequest !== 1'b0) begin failures++; $display("FAIL rel_wr_waitrequest got=%b required=0", wr_waitrequest); end
    endtask

    task automatic test_wr_rd_basic();
        int last, acc;
        clear_mon();
        wr_beats(48'h10, 7'd4, 64'd1, 4, 8'hFF, last);
        tick(3);
        checks++;
        if (rsp_cyc.size() != 1) begin
            failures++; $display("FAIL basic_wr_rsp_count got=%0d required=1", rsp_cyc.size());
        end else begin
            checks += 2;
            if (rsp_cyc[0] != last + 1) begin failures++; $display("FAIL basic_wr_rsp_cycle got=%0d required=%0d", rsp_cyc[0], last + 1); end
            if (rsp_code[0] !== 2'b00)  begin failures++; $display("FAIL basic_wr_rsp_code got=%b required=00", rsp_code[0]); end
        end
        exp_q = '{64'd1, 64'd2, 64'd3, 64'd4};
        rd_cmd(48'h10, 7'd4, acc);
        tick(5);
        checks++;
        if (got_data.size() != 4) begin failures++; $display("FAIL basic_rd_count got=%0d required=4", got_data.size()); end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks += 3;
            if (got_data[i] !== exp_q[i]) begin failures++; $display("FAIL basic_rd_data[%0d] got=%h required=%h", i, got_data[i], exp_q[i]); end
            if (got_cyc[i] != acc + 1 + i) begin failures++; $display("FAIL basic_rd_cycle[%0d] got=%0d required=%0d", i, got_cyc[i], acc + 1 + i); end
            if (got_resp[i] !== 2'b00)     begin failures++; $display("FAIL basic_rd_resp[%0d] got=%b required=00", i, got_resp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        clear_mon();
        rd_cmd(48'h10, 7'd2, a1);
        rd_cmd(48'h11, 7'd3, a2);
        tick(6);
        checks++;
        if (a2 != a1 + 2) begin failures++; $display("FAIL b2b_accept_cycle got=%0d required=%0d", a2, a1 + 2); end
        exp_q = '{64'd1, 64'd2, 64'd2, 64'd3, 64'd4};
        checks++;
        if (got_data.size() != 5) begin failures++; $display("FAIL b2b_count got=%0d required=5", got_data.size()); end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks += 2;
            if (got_data[i] !== exp_q[i])  begin failures++; $display("FAIL b2b_data[%0d] got=%h required=%h", i, got_data[i], exp_q[i]); end
            if (got_cyc[i] != a1 + 1 + i)  begin failures++; $display("FAIL b2b_cycle[%0d] got=%0d required=%0d", i, got_cyc[i], a1 + 1 + i); end
        end
    endtask

    task automatic test_wrap();
        int last, acc;
        clear_mon();
        wr_beats(48'h3FE, 7'd4, 64'h11, 4, 8'hFF, last);
        tick(3);
        checks++;
        if (rsp_cyc.size() != 1) begin failures++; $display("FAIL wrap_wr_rsp_count got=%0d required=1", rsp_cyc.size()); end
        exp_q = '{64'h11, 64'h12, 64'h13, 64'h14, 64'h13, 64'h14};
        rd_cmd(48'h3FE, 7'd4, acc);
        tick(5);
        // Upper address bits alias onto the same array index 0.
        rd_cmd(48'hABCD_0000_0400, 7'd2, acc);
        tick(3);
        checks++;
        if (got_data.size() != 6) begin failures++; $display("FAIL wrap_rd_count got=%0d required=6", got_data.size()); end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_data[%0d] got=%h required=%h", i, got_data[i], exp_q[i]); end
        end
    endtask

    task automatic test_collision();
        int last, acc;
        clear_mon();
        wr_beats(48'h5, 7'd1, 64'hAA, 1, 8'hFF, last);
        tick(3);
        rd_address = 48'h5; rd_burstcount = 7'd1; rd_read = 1'b1;
        wr_address = 48'h5; wr_burstcount = 7'd1; wr_writedata = 64'hBB;
        wr_byteenable = 8'hFF; wr_write = 1'b1;
        checks++;
        if (rd_waitrequest !== 1'b0) begin failures++; $display("FAIL coll_waitrequest got=%b required=0", rd_waitrequest); end
        tick(1);
        rd_read = 1'b0; wr_write = 1'b0;
        tick(3);
        rd_cmd(48'h5, 7'd1, acc);
        tick(3);
        wr_beats(48'h5, 7'd1, 64'hFFFF_FFFF_FFFF_FF12, 1, 8'h01, last);
        tick(3);
        rd_cmd(48'h5, 7'd1, acc);
        tick(3);
        exp_q = '{64'hAA, 64'hBB, 64'h12};
        checks++;
        if (got_data.size() != 3) begin failures++; $display("FAIL coll_count got=%0d required=3", got_data.size()); end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_q[i]) begin failures++; $display("FAIL coll_data[%0d] got=%h required=%h", i, got_data[i], exp_q[i]); end
        end
        checks++;
        if (rsp_cyc.size() != 3) begin failures++; $display("FAIL coll_wr_rsp_count got=%0d required=3", rsp_cyc.size()); end
    endtask

    task automatic test_bad_burst();
        int last, acc;
        clear_mon();
        rd_cmd(48'h10, 7'd0, acc);
        tick(4);
        checks++;
        if (err !== exp_err) begin failures++; $display("FAIL bad_err got=%b required=%b", err, exp_err); end
        rd_cmd(48'h10, 7'd65, acc);
        tick(4);
        wr_beats(48'h30, 7'd0, 64'h77, 1, 8'hFF, last);
        tick(3);
        rd_cmd(48'h30, 7'd1, acc);
        tick(3);
        exp_q = '{64'd1, 64'd1, 64'h77};
        checks++;
        if (got_data.size() != 3) begin failures++; $display("FAIL bad_rd_count got=%0d required=3", got_data.size()); end
        for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
            checks += 2;
            if (got_data[i] !== exp_q[i]) begin failures++; $display("FAIL bad_rd_data[%0d] got=%h required=%h", i, got_data[i], exp_q[i]); end
            if (got_resp[i] !== ((i < 2) ? 2'b10 : 2'b00)) begin
                failures++; $display("FAIL bad_rd_resp[%0d] got=%b required=%b", i, got_resp[i], (i < 2) ? 2'b10 : 2'b00);
            end
        end
        checks++;
        if (rsp_cyc.size() != 1) begin
            failures++; $display("FAIL bad_wr_rsp_count got=%0d required=1", rsp_cyc.size());
        end else begin
            checks++;
            if (rsp_code[0] !== 2'b10) begin failures++; $display("FAIL bad_wr_rsp_code got=%b required=10", rsp_code[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int last, acc;
        clear_mon();
        wr_beats(48'h40, 7'd4, 64'h5, 2, 8'hFF, last);   // half a burst, left open
        rd_cmd(48'h10, 7'd8, acc);
        tick(2);
        checks++;
        if (rd_readdatavalid !== 1'b1) begin failures++; $display("FAIL mid_beat3_valid got=%b required=1", rd_readdatavalid); end
        #2;
        reset_n = 1'b0;
        #1;
        checks += 3;
        if (rd_readdatavalid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b required=0", rd_readdatavalid); end
        if (rd_waitrequest !== 1'b1)   begin failures++; $display("FAIL mid_rd_waitrequest got=%b required=1", rd_waitrequest); end
        if (wr_waitrequest !== 1'b1)   begin failures++; $display("FAIL mid_wr_waitrequest got=%b required=1", wr_waitrequest); end
        clear_mon();
        tick(2);
        reset_n = 1'b1;
        checks++;
        if (rd_waitrequest !== 1'b1) begin failures++; $display("FAIL mid_rel_hold got=%b required=1", rd_waitrequest); end
        tick(1);
        checks += 2;
        if (rd_waitrequest !== 1'b0) begin failures++; $display("FAIL mid_rel_rd_waitrequest got=%b required=0", rd_waitrequest); end
        if (wr_waitrequest !== 1'b0) begin failures++; $display("FAIL mid_rel_wr_waitrequest got=%b required=0", wr_waitrequest); end
        tick(10);
        checks += 3;
        if (got_data.size() != 0) begin failures++; $display("FAIL mid_no_beats got=%0d required=0", got_data.size()); end
        if (rsp_cyc.size() != 0)  begin failures++; $display("FAIL mid_no_wr_rsp got=%0d required=0", rsp_cyc.size()); end
        if (err !== 1'b0)         begin failures++; $display("FAIL mid_err got=%b required=0", err); end
        wr_beats(48'h40, 7'd1, 64'h9, 1, 8'hFF, last);
        tick(3);
        checks++;
        if (rsp_cyc.size() != 1) begin failures++; $display("FAIL mid_fresh_wr_rsp got=%0d required=1", rsp_cyc.size()); end
    endtask

    initial begin
`ifdef OFS_PLAT_AVALON_RESPONDER_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        reset_n       = 1'b0;
        rd_address    = '0;
        rd_read       = 1'b0;
        rd_burstcount = 7'd1;
        rd_byteenable = '1;
        wr_address    = '0;
        wr_write      = 1'b0;
        wr_burstcount = 7'd1;
        wr_writedata  = '0;
        wr_byteenable = '1;
        test_reset();
        test_wr_rd_basic();
        test_back_to_back();
        test_wrap();
        test_collision();
        test_bad_burst();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
